// File: rtl/cpu_mem_scheduler.sv
// rtl/cpu_mem_scheduler.sv - time-division RAM port scheduler for the 6502 CPU and one DMA reader
module cpu_mem_scheduler #(
    parameter int CPU_DIV   = 4,
    parameter int MAX_BURST = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        cpu_enable,
    output logic        cpu_ready,
    input  logic [15:0] cpu_ab,
    input  logic [7:0]  cpu_dbo,
    input  logic        cpu_we,
    output logic [7:0]  cpu_dbi,
    input  logic        dma_req,
    input  logic        dma_burst,
    input  logic [15:0] dma_addr,
    output logic        dma_ack,
    output logic [7:0]  dma_data,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_din,
    output logic        mem_we,
    input  logic [7:0]  mem_dout
);
    localparam int PW = $clog2(CPU_DIV);
    localparam int SW = $clog2(MAX_BURST + 1);
    localparam logic [PW-1:0] PH_LAST   = PW'(CPU_DIV - 1);
    localparam logic [PW-1:0] PH_ONE    = PW'(1);
    localparam logic [SW-1:0] STEAL_MAX = SW'(MAX_BURST);

    logic [PW-1:0] phase_q, phase_d;
    logic          cpu_enable_q, cpu_enable_d;
    logic          cpu_ready_q, cpu_ready_d;
    logic [7:0]    cpu_dbi_q, cpu_dbi_d;
    logic          cpu_rd_q, cpu_rd_d;
    logic          dma_ack_q, dma_ack_d;
    logic [SW-1:0] steal_cnt_q, steal_cnt_d;
    logic          cpu_slot, dma_slot, dma_issue;

    always_comb begin
        cpu_slot     = (phase_q == '0) && cpu_ready_q;
        // A stolen phase 0 behaves exactly like an extra DMA slot.
        dma_slot     = (phase_q != PH_LAST) && !cpu_slot;
        dma_issue    = dma_slot && dma_req && !dma_ack_q;
        phase_d      = (phase_q == PH_LAST) ? '0 : phase_q + PH_ONE;
        cpu_enable_d = (phase_d == PH_LAST);
        dma_ack_d    = dma_issue;

        cpu_rd_d  = cpu_rd_q;
        cpu_dbi_d = cpu_dbi_q;
        if (cpu_slot) begin
            cpu_rd_d = !cpu_we;
        end else if (phase_q == PH_ONE) begin
            cpu_rd_d = 1'b0;
            if (cpu_rd_q) begin
                cpu_dbi_d = mem_dout;
            end
        end

        cpu_ready_d = cpu_ready_q;
        steal_cnt_d = steal_cnt_q;
        if (phase_q == PH_LAST) begin
            if (dma_req && dma_burst && (steal_cnt_q < STEAL_MAX)) begin
                cpu_ready_d = 1'b0;
                steal_cnt_d = steal_cnt_q + SW'(1);
            end else begin
                cpu_ready_d = 1'b1;
                steal_cnt_d = '0;
            end
        end
    end

    always_comb begin
        mem_addr = '0;
        mem_din  = '0;
        mem_we   = 1'b0;
        if (reset_n) begin
            if (cpu_slot) begin
                mem_addr = cpu_ab;
                mem_din  = cpu_dbo;
                mem_we   = cpu_we;
            end else if (dma_issue) begin
                mem_addr = dma_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q      <= '0;
            cpu_enable_q <= 1'b0;
            cpu_ready_q  <= 1'b1;
            cpu_dbi_q    <= '0;
            cpu_rd_q     <= 1'b0;
            dma_ack_q    <= 1'b0;
            steal_cnt_q  <= '0;
        end else begin
            phase_q      <= phase_d;
            cpu_enable_q <= cpu_enable_d;
            cpu_ready_q  <= cpu_ready_d;
            cpu_dbi_q    <= cpu_dbi_d;
            cpu_rd_q     <= cpu_rd_d;
            dma_ack_q    <= dma_ack_d;
            steal_cnt_q  <= steal_cnt_d;
        end
    end

    assign cpu_enable = cpu_enable_q;
    assign cpu_ready  = cpu_ready_q;
    assign cpu_dbi    = cpu_dbi_q;
    assign dma_ack    = dma_ack_q;
    assign dma_data   = dma_ack_q ? mem_dout : 8'h00;

endmodule

// File: tb/tb_cpu_mem_scheduler.sv
// tb/tb_cpu_mem_scheduler.sv - directed bench for cpu_mem_scheduler (CPU_DIV=4 and CPU_DIV=6 instances)
module tb_cpu_mem_scheduler;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] cpu_ab, dma_addr;
    logic [7:0]  cpu_dbo;
    logic        cpu_we, dma_req, dma_burst;

    logic        cpu_enable_a, cpu_ready_a, dma_ack_a, mem_we_a;
    logic [7:0]  cpu_dbi_a, dma_data_a, mem_din_a, mem_dout_a;
    logic [15:0] mem_addr_a;
    logic        cpu_enable_b, cpu_ready_b, dma_ack_b, mem_we_b;
    logic [7:0]  cpu_dbi_b, dma_data_b, mem_din_b, mem_dout_b;
    logic [15:0] mem_addr_b;

    logic [7:0] ram_a [0:65535];
    logic [7:0] ram_b [0:65535];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    cpu_mem_scheduler #(.CPU_DIV(4), .MAX_BURST(8)) dut_a (
        .clk(clk), .reset_n(reset_n), .cpu_enable(cpu_enable_a), .cpu_ready(cpu_ready_a),
        .cpu_ab(cpu_ab), .cpu_dbo(cpu_dbo), .cpu_we(cpu_we), .cpu_dbi(cpu_dbi_a),
        .dma_req(dma_req), .dma_burst(dma_burst), .dma_addr(dma_addr), .dma_ack(dma_ack_a),
        .dma_data(dma_data_a), .mem_addr(mem_addr_a), .mem_din(mem_din_a), .mem_we(mem_we_a),
        .mem_dout(mem_dout_a)
    );

    cpu_mem_scheduler #(.CPU_DIV(6), .MAX_BURST(8)) dut_b (
        .clk(clk), .reset_n(reset_n), .cpu_enable(cpu_enable_b), .cpu_ready(cpu_ready_b),
        .cpu_ab(cpu_ab), .cpu_dbo(cpu_dbo), .cpu_we(cpu_we), .cpu_dbi(cpu_dbi_b),
        .dma_req(dma_req), .dma_burst(dma_burst), .dma_addr(dma_addr), .dma_ack(dma_ack_b),
        .dma_data(dma_data_b), .mem_addr(mem_addr_b), .mem_din(mem_din_b), .mem_we(mem_we_b),
        .mem_dout(mem_dout_b)
    );

    always @(posedge clk) begin
        if (mem_we_a) ram_a[mem_addr_a] <= mem_din_a;
        mem_dout_a <= ram_a[mem_addr_a];
        if (mem_we_b) ram_b[mem_addr_b] <= mem_din_b;
        mem_dout_b <= ram_b[mem_addr_b];
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        cpu_ab = '0; cpu_dbo = '0; cpu_we = 1'b0;
        dma_req = 1'b0; dma_burst = 1'b0; dma_addr = '0;
    endtask

    task automatic goto_phase_a(input int p);
        while ((cyc % 4) != p) tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        cpu_ab = 16'h1234; cpu_dbo = 8'hFF; cpu_we = 1'b1; dma_req = 1'b1; dma_addr = 16'h7800;
        reset_n = 1'b0;
        #1;
        tests++;
        if ({mem_addr_a, mem_din_a, mem_we_a} !== 25'h0) begin
            fails++;
            $display("FAIL reset_mem: got addr=%h din=%h we=%b expected 0000/00/0", mem_addr_a, mem_din_a, mem_we_a);
        end
        tick(); tick();
        tests++;
        if ({cpu_enable_a, cpu_ready_a, cpu_dbi_a, dma_ack_a} !== {1'b0, 1'b1, 8'h00, 1'b0}) begin
            fails++;
            $display("FAIL reset_regs: got en=%b rdy=%b dbi=%h ack=%b expected 0/1/00/0",
                     cpu_enable_a, cpu_ready_a, cpu_dbi_a, dma_ack_a);
        end
        idle_inputs();
        reset_n = 1'b1;
        cyc = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            tests++;
            if (cpu_enable_a !== ((cyc % 4) == 3) || cpu_ready_a !== 1'b1 || mem_we_a !== 1'b0) begin
                fails++;
                $display("FAIL release_a clk%0d: got en=%b rdy=%b we=%b expected en=%b rdy=1 we=0",
                         cyc, cpu_enable_a, cpu_ready_a, mem_we_a, (cyc % 4) == 3);
            end
            tests++;
            if (cpu_enable_b !== ((cyc % 6) == 5)) begin
                fails++;
                $display("FAIL release_b clk%0d: got en=%b expected %b", cyc, cpu_enable_b, (cyc % 6) == 5);
            end
            tick();
        end
    endtask

    task automatic test_cpu_write_read();
        goto_phase_a(0);
        cpu_ab = 16'h0200; cpu_dbo = 8'hA5; cpu_we = 1'b1;
        #1;
        tests++;
        if (mem_addr_a !== 16'h0200 || mem_din_a !== 8'hA5 || mem_we_a !== 1'b1) begin
            fails++;
            $display("FAIL cpu_write: got addr=%h din=%h we=%b expected 0200/a5/1", mem_addr_a, mem_din_a, mem_we_a);
        end
        tick();
        for (int p = 1; p < 4; p++) begin
            #1;
            tests++;
            if (mem_we_a !== 1'b0 || mem_addr_a !== 16'h0000) begin
                fails++;
                $display("FAIL cpu_write_ph%0d: got addr=%h we=%b expected 0000/0", p, mem_addr_a, mem_we_a);
            end
            tick();
        end
        cpu_we = 1'b0;
        #1;
        tests++;
        if (mem_addr_a !== 16'h0200 || mem_we_a !== 1'b0) begin
            fails++;
            $display("FAIL cpu_read_addr: got addr=%h we=%b expected 0200/0", mem_addr_a, mem_we_a);
        end
        tick(); tick();
        for (int p = 2; p < 4; p++) begin
            #1;
            tests++;
            if (cpu_dbi_a !== 8'hA5) begin
                fails++;
                $display("FAIL cpu_read_ph%0d: got dbi=%h expected a5", p, cpu_dbi_a);
            end
            tick();
        end
    endtask

    task automatic test_dma_single();
        int acks;
        logic [15:0] exp_addr;
        goto_phase_a(0);
        cpu_ab = 16'h0200; cpu_we = 1'b0; dma_req = 1'b1; dma_addr = 16'h7800; dma_burst = 1'b0;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            case (i % 4)
                0:       exp_addr = 16'h0200;
                1:       exp_addr = 16'h7800;
                default: exp_addr = 16'h0000;
            endcase
            if (dma_ack_a === 1'b1) acks++;
            tests++;
            if (mem_addr_a !== exp_addr || mem_we_a !== 1'b0 || dma_ack_a !== ((i % 4) == 2) || cpu_ready_a !== 1'b1) begin
                fails++;
                $display("FAIL dma_single ph%0d: got addr=%h we=%b ack=%b rdy=%b expected addr=%h we=0 ack=%b rdy=1",
                         i % 4, mem_addr_a, mem_we_a, dma_ack_a, cpu_ready_a, exp_addr, (i % 4) == 2);
            end
            if ((i % 4) == 2) begin
                tests++;
                if (dma_data_a !== 8'h3C) begin
                    fails++;
                    $display("FAIL dma_data: got %h expected 3c", dma_data_a);
                end
            end
            tick();
        end
        tests++;
        if (acks != 2) begin
            fails++;
            $display("FAIL dma_ack_count: got %0d expected 2", acks);
        end
        dma_req = 1'b0;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (dma_ack_a !== 1'b0 || (i == 1 && mem_addr_a !== 16'h0000)) acks++;
            tick();
        end
        tests++;
        if (acks != 0) begin
            fails++;
            $display("FAIL dma_no_req: got %0d ack/issue events expected 0", acks);
        end
        dma_req = 1'b1;
        tick();
        #1;
        tests++;
        if (mem_addr_a !== 16'h7800) begin
            fails++;
            $display("FAIL dma_issue_late_drop: got addr=%h expected 7800", mem_addr_a);
        end
        tick();
        dma_req = 1'b0;
        #1;
        tests++;
        if (dma_ack_a !== 1'b1 || dma_data_a !== 8'h3C) begin
            fails++;
            $display("FAIL dma_ack_after_drop: got ack=%b data=%h expected 1/3c", dma_ack_a, dma_data_a);
        end
        tick();
        #1;
        tests++;
        if (dma_ack_a !== 1'b0) begin
            fails++;
            $display("FAIL dma_ack_pulse: got ack=%b expected 0", dma_ack_a);
        end
        tick();
    endtask

    task automatic test_burst();
        logic exp_rdy, exp_we;
        goto_phase_a(0);
        cpu_ab = 16'h0200; cpu_we = 1'b0; dma_req = 1'b1; dma_burst = 1'b1; dma_addr = 16'h7800;
        for (int c = 0; c < 11; c++) begin
            for (int p = 0; p < 4; p++) begin
                if (c == 1 && p == 0) begin
                    cpu_ab = 16'h0300; cpu_dbo = 8'h5A; cpu_we = 1'b1;
                end
                if (c == 9 && p == 1) cpu_we = 1'b0;
                #1;
                exp_rdy = (c == 0) || (c == 9);
                exp_we  = (c == 9) && (p == 0);
                tests++;
                if (cpu_ready_a !== exp_rdy || mem_we_a !== exp_we) begin
                    fails++;
                    $display("FAIL burst c%0d p%0d: got rdy=%b we=%b expected rdy=%b we=%b",
                             c, p, cpu_ready_a, mem_we_a, exp_rdy, exp_we);
                end
                if (exp_we) begin
                    tests++;
                    if (mem_addr_a !== 16'h0300 || mem_din_a !== 8'h5A) begin
                        fails++;
                        $display("FAIL burst_write: got addr=%h din=%h expected 0300/5a", mem_addr_a, mem_din_a);
                    end
                end
                tick();
            end
        end
        idle_inputs();
        tests++;
        if (ram_a[16'h0300] !== 8'h5A) begin
            fails++;
            $display("FAIL burst_ram: got %h expected 5a", ram_a[16'h0300]);
        end
    endtask

    task automatic test_div6();
        logic [15:0] exp_addr;
        reset_n = 1'b0;
        tick(); tick();
        idle_inputs();
        cpu_ab = 16'h0010; dma_req = 1'b1; dma_addr = 16'h7800;
        reset_n = 1'b1;
        cyc = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            case (cyc % 6)
                0:       exp_addr = 16'h0010;
                1, 3:    exp_addr = 16'h7800;
                default: exp_addr = 16'h0000;
            endcase
            tests++;
            if (mem_addr_b !== exp_addr || dma_ack_b !== ((cyc % 6) == 2 || (cyc % 6) == 4)) begin
                fails++;
                $display("FAIL div6 ph%0d: got addr=%h ack=%b expected addr=%h ack=%b", cyc % 6,
                         mem_addr_b, dma_ack_b, exp_addr, (cyc % 6) == 2 || (cyc % 6) == 4);
            end
            if (dma_ack_b === 1'b1) begin
                tests++;
                if (dma_data_b !== 8'h3C) begin
                    fails++;
                    $display("FAIL div6_data: got %h expected 3c", dma_data_b);
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_issue();
        goto_phase_a(1);
        #1;
        tests++;
        if (mem_addr_a !== 16'h7800) begin
            fails++;
            $display("FAIL mid_issue_pre: got addr=%h expected 7800", mem_addr_a);
        end
        reset_n = 1'b0;
        #1;
        tests++;
        if ({mem_addr_a, mem_we_a, dma_ack_a, cpu_enable_a, cpu_ready_a, cpu_dbi_a} !== {16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00}) begin
            fails++;
            $display("FAIL mid_issue_reset: got addr=%h we=%b ack=%b en=%b rdy=%b dbi=%h expected 0000/0/0/0/1/00",
                     mem_addr_a, mem_we_a, dma_ack_a, cpu_enable_a, cpu_ready_a, cpu_dbi_a);
        end
        tick();
        tests++;
        if (dma_ack_a !== 1'b0) begin
            fails++;
            $display("FAIL mid_issue_ack: got ack=%b expected 0", dma_ack_a);
        end
        idle_inputs();
        reset_n = 1'b1;
        cyc = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            tests++;
            if (cpu_enable_a !== ((cyc % 4) == 3) || dma_ack_a !== 1'b0) begin
                fails++;
                $display("FAIL restart clk%0d: got en=%b ack=%b expected en=%b ack=0",
                         cyc, cpu_enable_a, dma_ack_a, (cyc % 4) == 3);
            end
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            ram_a[i] = 8'h00;
            ram_b[i] = 8'h00;
        end
        ram_a[16'h7800] = 8'h3C;
        ram_b[16'h7800] = 8'h3C;
        test_reset();
        test_cpu_write_read();
        test_dma_single();
        test_burst();
        test_div6();
        test_reset_mid_issue();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
